// File: rtl/stop_button_frontend.sv
// Stop-button front end: 2-FF synchronizer, debounce FSM, press strobe and a one-entry LED snapshot buffer.
// Define HOLD_REPEAT_EN to re-issue press_pulse every REPEAT_CYCLES while the button stays pressed.
module stop_button_frontend #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int LED_W           = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_raw,
  input  logic [LED_W-1:0] led_pos,
  input  logic             press_ack,
  output logic             press_pulse,
  output logic             press_valid,
  output logic [LED_W-1:0] press_led,
  output logic             held,
  output logic             overrun,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             pulse_q, pulse_d;
  logic             debounce_fire;
  logic             repeat_fire;
  logic             valid_q, valid_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             overrun_q, overrun_d;

  // Only s2_q may be observed downstream; s1_q absorbs metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= button_raw;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    held_d        = held_q;
    debounce_fire = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s2_q) begin
          cnt_d   = CNT_ONE;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          cnt_d   = '0;
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d         = '0;
          state_d       = PRESSED;
          held_d        = 1'b1;
          debounce_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RELEASED;
          held_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RELEASED;
        held_d  = 1'b0;
      end
    endcase
  end

`ifdef HOLD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [REP_W-1:0] rep_q, rep_d;

  // Counts only while PRESSED is being held; any exit from PRESSED restarts the period.
  always_comb begin
    rep_d       = '0;
    repeat_fire = 1'b0;
    if ((state_q == PRESSED) && s2_q) begin
      if (rep_q == REP_LAST) begin
        repeat_fire = 1'b1;
      end else begin
        rep_d = rep_q + REP_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = (REPEAT_CYCLES != 0);
  assign repeat_fire          = 1'b0;
`endif

  assign pulse_d = debounce_fire | repeat_fire;

  // Handshake: press_valid high means press_led holds an unconsumed event; the consumer
  // raises press_ack for one cycle to take it. An ack in a press_pulse cycle makes room
  // for the new event in the same cycle; an ack with nothing pending is ignored.
  always_comb begin
    valid_d   = valid_q;
    led_d     = led_q;
    overrun_d = overrun_q;
    if (pulse_q) begin
      if (!valid_q || press_ack) begin
        valid_d = 1'b1;
        led_d   = led_pos;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && press_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      pulse_q   <= 1'b0;
      valid_q   <= 1'b0;
      led_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      pulse_q   <= pulse_d;
      valid_q   <= valid_d;
      led_q     <= led_d;
      overrun_q <= overrun_d;
    end
  end

  assign press_pulse = pulse_q;
  assign press_valid = valid_q;
  assign press_led   = led_q;
  assign held        = held_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stop_button_frontend.sv
// Bench for stop_button_frontend: directed scenarios plus random bursts against a window-based reference model.
// Build with HOLD_REPEAT_EN defined to exercise the auto-repeat expectations.
module tb_stop_button_frontend;
  localparam int D  = 4;
  localparam int LW = 4;
  localparam int R  = 8;
  localparam int OW = LW + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          button_raw;
  logic [LW-1:0] led_pos;
  logic          press_ack;
  logic          press_pulse, press_valid, held, overrun;
  logic [LW-1:0] press_led;
  logic [1:0]    dbg_state;

  int vectors = 0;
  int errors  = 0;
  logic [OW-1:0] exp_q[$];

  stop_button_frontend #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(16),
    .LED_W(LW),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button_raw(button_raw),
    .led_pos(led_pos),
    .press_ack(press_ack),
    .press_pulse(press_pulse),
    .press_valid(press_valid),
    .press_led(press_led),
    .held(held),
    .overrun(overrun),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: a level change is accepted once the last D synchronized samples all differ from held.
  logic          m_pulse, m_valid, m_held, m_ovr;
  logic [LW-1:0] m_led;
  logic          sync_q[$];
  logic          win_q[$];
`ifdef HOLD_REPEAT_EN
  logic          m_last_s2;
  int            m_age;
`endif

  always @(posedge clk) begin : model
    logic s2, flip, fire;
`ifdef HOLD_REPEAT_EN
    logic in_pressed;
`endif
    if (reset) begin
      m_pulse = 1'b0; m_valid = 1'b0; m_held = 1'b0; m_ovr = 1'b0; m_led = '0;
      sync_q = '{1'b0, 1'b0};
      win_q.delete();
      for (int i = 0; i < D; i++) win_q.push_back(1'b0);
`ifdef HOLD_REPEAT_EN
      m_age = 0; m_last_s2 = 1'b0;
`endif
    end else begin
      if (m_pulse) begin
        if (!m_valid || press_ack) begin
          m_valid = 1'b1;
          m_led   = led_pos;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && press_ack) begin
        m_valid = 1'b0;
      end
      s2 = sync_q.pop_front();
      sync_q.push_back(button_raw);
`ifdef HOLD_REPEAT_EN
      in_pressed = m_held && m_last_s2;
`endif
      win_q.push_back(s2);
      void'(win_q.pop_front());
      flip = 1'b1;
      foreach (win_q[i]) if (win_q[i] == m_held) flip = 1'b0;
      fire = 1'b0;
      if (flip) begin
        m_held = !m_held;
        fire   = m_held;
      end
`ifdef HOLD_REPEAT_EN
      if (in_pressed && s2) begin
        m_age++;
        if (m_age == R) begin
          fire  = 1'b1;
          m_age = 0;
        end
      end else begin
        m_age = 0;
      end
      m_last_s2 = s2;
`endif
      m_pulse = fire;
    end
    exp_q.push_back({m_pulse, m_valid, m_led, m_held, m_ovr});
  end

  // Scoreboard: every cycle's outputs against the model's expectation for that cycle.
  always @(negedge clk) begin : scoreboard
    logic [OW-1:0] exp_v, obs_v;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      obs_v = {press_pulse, press_valid, press_led, held, overrun};
      vectors++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL scoreboard t=%0t got={pulse,valid,led,held,ovr}=%b exp=%b", $time, obs_v, exp_v);
      end
    end
  end

  task automatic drive(input logic raw, input logic [LW-1:0] led, input logic ack);
    button_raw = raw;
    led_pos    = led;
    press_ack  = ack;
  endtask

  task automatic settle(input logic raw, input int n);
    button_raw = raw;
    press_ack  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({press_pulse, press_valid, press_led, held, overrun} !== '0 || dbg_state !== 2'd0) begin
        errors++;
        $display("FAIL reset_state got=%b/%0d exp=0/0",
                 {press_pulse, press_valid, press_led, held, overrun}, dbg_state);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    int first = -1;
    drive(1'b1, 4'b0100, 1'b0);
    for (int k = 1; k <= D + 3; k++) begin
      @(negedge clk);
      if (press_pulse && first < 0) first = k;
      vectors++;
      if (press_pulse !== (k == D + 2) || held !== (k >= D + 2)) begin
        errors++;
        $display("FAIL clean_press k=%0d got pulse=%b held=%b exp pulse=%b held=%b",
                 k, press_pulse, held, (k == D + 2), (k >= D + 2));
      end
    end
    vectors++;
    if (first != D + 2) begin
      errors++;
      $display("FAIL clean_latency got=%0d exp=%0d", first, D + 2);
    end
    vectors++;
    if (press_valid !== 1'b1 || press_led !== 4'b0100) begin
      errors++;
      $display("FAIL clean_capture got valid=%b led=%b exp valid=1 led=0100", press_valid, press_led);
    end
  endtask

  task automatic test_release();
    drive(1'b0, 4'b0100, 1'b0);
    for (int k = 1; k <= D + 4; k++) begin
      @(negedge clk);
      vectors++;
      if (held !== (k < D + 2) || press_pulse !== 1'b0) begin
        errors++;
        $display("FAIL release k=%0d got held=%b pulse=%b exp held=%b pulse=0",
                 k, held, press_pulse, (k < D + 2));
      end
    end
  endtask

  task automatic test_simultaneous_ack();
    drive(1'b1, 4'b1000, 1'b0);
    for (int k = 1; k <= D + 3; k++) begin
      @(negedge clk);
      if (k == D + 2) begin
        vectors++;
        if (press_pulse !== 1'b1) begin
          errors++;
          $display("FAIL simul_pulse got=%b exp=1", press_pulse);
        end
        press_ack = 1'b1;
      end else begin
        press_ack = 1'b0;
      end
    end
    vectors++;
    if (press_valid !== 1'b1 || press_led !== 4'b1000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL simul_ack got valid=%b led=%b ovr=%b exp valid=1 led=1000 ovr=0",
               press_valid, press_led, overrun);
    end
    settle(1'b0, D + 4);
  endtask

  task automatic test_bounce();
    logic pat [0:6];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drive((i < 7) ? pat[i] : 1'b0, 4'b0010, (i == 0));
      @(negedge clk);
      vectors++;
      if (press_pulse !== 1'b0 || held !== 1'b0 || (i > 0 && press_valid !== 1'b0)) begin
        errors++;
        $display("FAIL bounce i=%0d got pulse=%b held=%b valid=%b exp 0/0/0",
                 i, press_pulse, held, press_valid);
      end
    end
    drive(1'b1, 4'b0010, 1'b0);
    for (int k = 1; k <= D + 3; k++) begin
      @(negedge clk);
      vectors++;
      if (press_pulse !== (k == D + 2)) begin
        errors++;
        $display("FAIL bounce_steady k=%0d got pulse=%b exp=%b", k, press_pulse, (k == D + 2));
      end
    end
    vectors++;
    if (press_valid !== 1'b1 || press_led !== 4'b0010) begin
      errors++;
      $display("FAIL bounce_capture got valid=%b led=%b exp valid=1 led=0010", press_valid, press_led);
    end
    settle(1'b0, D + 4);
  endtask

  task automatic test_ack_overrun();
    drive(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    press_ack = 1'b0;
    vectors++;
    if (press_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear got valid=%b exp=0", press_valid);
    end
    drive(1'b1, 4'b0001, 1'b0);
    repeat (D + 3) @(negedge clk);
    vectors++;
    if (press_valid !== 1'b1 || press_led !== 4'b0001 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL second_press got valid=%b led=%b ovr=%b exp 1/0001/0", press_valid, press_led, overrun);
    end
    settle(1'b0, D + 4);
    drive(1'b1, 4'b0100, 1'b0);
    repeat (D + 3) @(negedge clk);
    vectors++;
    if (press_valid !== 1'b1 || press_led !== 4'b0001 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun got valid=%b led=%b ovr=%b exp 1/0001/1", press_valid, press_led, overrun);
    end
    settle(1'b0, D + 4);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b1000, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({press_pulse, press_valid, press_led, held, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_mid got=%b exp=0", {press_pulse, press_valid, press_led, held, overrun});
    end
    reset = 1'b0;
    for (int j = 1; j <= D + 3; j++) begin
      @(negedge clk);
      vectors++;
      if (press_pulse !== (j == D + 2) || held !== (j >= D + 2)) begin
        errors++;
        $display("FAIL reset_redebounce j=%0d got pulse=%b held=%b exp pulse=%b held=%b",
                 j, press_pulse, held, (j == D + 2), (j >= D + 2));
      end
    end
    settle(1'b0, D + 4);
  endtask

  task automatic test_hold_repeat();
    int   pulses = 0;
    int   exp_pulses;
    logic exp_p;
    drive(1'b1, 4'b0100, 1'b1);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      exp_p = (k == D + 2);
`ifdef HOLD_REPEAT_EN
      exp_p = exp_p || (k > D + 2 && k <= 35 && ((k - (D + 2)) % R) == 0);
`endif
      if (press_pulse) pulses++;
      vectors++;
      if (press_pulse !== exp_p) begin
        errors++;
        $display("FAIL hold_repeat k=%0d got pulse=%b exp=%b", k, press_pulse, exp_p);
      end
      if (k == 34) button_raw = 1'b0;
    end
`ifdef HOLD_REPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    vectors++;
    if (pulses != exp_pulses) begin
      errors++;
      $display("FAIL hold_pulse_count got=%0d exp=%0d", pulses, exp_pulses);
    end
    press_ack = 1'b0;
  endtask

  task automatic test_random();
    logic prev_ovr;
    for (int seg = 0; seg < 300; seg++) begin
      button_raw = 1'(($urandom_range(0, 1)));
      reset      = ($urandom_range(0, 59) == 0);
      for (int c = $urandom_range(1, 2 * D + 3); c > 0; c--) begin
        led_pos   = LW'($urandom_range(0, (1 << LW) - 1));
        press_ack = ($urandom_range(0, 2) == 0);
        prev_ovr  = overrun;
        @(negedge clk);
        vectors++;
        if ((press_pulse && !held) || (prev_ovr && !overrun && !reset)) begin
          errors++;
          $display("FAIL random_invariant got pulse=%b held=%b ovr=%b->%b", press_pulse, held, prev_ovr, overrun);
        end
        reset = 1'b0;
      end
    end
    settle(1'b0, D + 4);
  endtask

  initial begin
    sync_q = '{1'b0, 1'b0};
    for (int i = 0; i < D; i++) win_q.push_back(1'b0);
    test_reset();
    test_clean_press();
    test_release();
    test_simultaneous_ack();
    test_bounce();
    test_ack_overrun();
    test_reset_mid();
    test_hold_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/stop_button_frontend.md
Name: stop_button_frontend

Overview:
- Player-side producer of the stop-button event consumed by the LED chase game's win/loss judge.
- Takes the raw asynchronous push-button and runs it through a 2-FF synchronizer and a debounce state machine.
- Emits a single-cycle press pulse and snapshots the one-hot LED position at that instant.
- Holds the snapshot in a one-entry valid/ack buffer until the game logic consumes it.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples required to accept a level change. Legal range is 2 to 65535.
- CNT_W, 16: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- LED_W, 4: width of the LED position vector.
- REPEAT_CYCLES, 64: auto-repeat period. Used only when HOLD_REPEAT_EN is defined.

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: synchronous, active-high reset.
- button_raw, input, 1: raw push-button level, asynchronous to clk, may bounce.
- led_pos, input, LED_W: current one-hot lit-LED position. 0 is legal (no LED lit yet).
- press_ack, input, 1: consumer acknowledge for the buffered event.
- press_pulse, output, 1: one-cycle strobe on each accepted press.
- press_valid, output, 1: a buffered press event is pending.
- press_led, output, LED_W: led_pos captured on the press_pulse cycle.
- held, output, 1: debounced button level.
- overrun, output, 1: sticky flag; a press was dropped because the buffer was full.

Behaviour:
- Reset: one clock is sampled with reset=1. Afterwards the synchronizer flops, counter, held, press_pulse, press_valid, press_led and overrun are all 0, and the FSM is in RELEASED.
  - Reset overrides every other input.
  - Reset mid-debounce or mid-event discards all pending state.
- Synchronizer:
  - s1 <= button_raw; s2 <= s1.
  - Only s2 feeds the FSM.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: if s2=1, set cnt=1 and go to PRESS_WAIT.
  - PRESS_WAIT:
    - s2=0: cnt=0, go to RELEASED (bounce rejected).
    - s2=1 and cnt==DEBOUNCE_CYCLES-1: go to PRESSED, set held=1, assert press_pulse for the next cycle only.
    - Otherwise: cnt++.
  - PRESSED: if s2=0, set cnt=1 and go to RELEASE_WAIT.
  - RELEASE_WAIT:
    - s2=1: cnt=0, return to PRESSED.
    - s2=0 and cnt==DEBOUNCE_CYCLES-1: go to RELEASED, set held=0. No pulse.
    - Otherwise: cnt++.
- Press latency: press_pulse rises exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples button_raw=1, provided the input stays high throughout.
- Release latency: held falls DEBOUNCE_CYCLES+2 edges after the first edge that samples button_raw=0, provided the input stays low throughout.
- Event buffer, evaluated on a press_pulse cycle P, with ack meaning press_ack=1 in that same cycle:
  - press_valid=0: next press_valid=1, press_led<=led_pos.
  - press_valid=1, ack=1: press_valid stays 1, press_led<=led_pos (back-to-back event).
  - press_valid=1, ack=0: old press_led is kept, new event dropped, overrun<=1.
- Event buffer, not a press_pulse cycle:
  - press_valid=1 and press_ack=1: press_valid<=0. press_led keeps its value.
  - press_ack while press_valid=0: ignored.
- overrun is cleared only by reset.
- press_led is captured verbatim, including 0 or non-one-hot values. No legality check.

Optional Feature:
- Macro: HOLD_REPEAT_EN.
- Defined:
  - While in PRESSED, a repeat counter runs.
  - Every REPEAT_CYCLES cycles after the initial press_pulse, press_pulse is re-asserted for one cycle, with the same buffer rules.
  - The repeat counter clears on leaving PRESSED and on reset.
- Undefined: exactly one press_pulse per debounced press. The repeat logic is absent and REPEAT_CYCLES is unused.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4, led_pos=4'b0100:
  - button_raw 0->1 and held → press_pulse high for 1 cycle, 6 edges after the first sample.
  - press_valid=1, press_led=4'b0100, held=1.
- Bounce, DEBOUNCE_CYCLES=4:
  - button_raw pattern 1,1,0,1,1,0 then 0 → no press_pulse, held stays 0.
  - A subsequent steady 1 → pulse after the full 6 edges.
- Ack, then a second press with no ack:
  - press_ack=1 for 1 cycle → press_valid=0.
  - Second press with led_pos=4'b0001 → press_led=4'b0001.
  - Third press without ack → overrun=1, press_led remains 4'b0001.
- Simultaneous ack and press:
  - press_ack=1 in the press_pulse cycle with led_pos=4'b1000 → press_valid stays 1, press_led=4'b1000, overrun=0.
- Reset mid-operation:
  - Assert reset during PRESS_WAIT with press_valid=1 and overrun=1 → all outputs 0 the cycle after reset.
  - After release, the button must debounce from scratch.
- HOLD_REPEAT_EN, REPEAT_CYCLES=8:
  - Hold the button for 30 cycles after the first pulse, acking each event → 3 further pulses at +8, +16 and +24 cycles.
  - No pulse after release.
